uart_frame_tx: RTL and testbench

- Synthesizable, parametrised UART transmitter for the DE0-Nano UART design.
- Successor to the bench's fixed 10-bit serializer. Adds a configurable data width, parity, stop bits, an internal baud generator and a write FIFO.
- Sits between the command/echo logic and the `uart_tx` pin. Also reused as the bench stimulus driver on `uart_rx`.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_frame_tx_if.sv | 24 ++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_frame_tx.sv | 183 ++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM encoding and divider helpers for uart_frame_tx (BREAK state under UART_TX_BREAK_EN)
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
`ifdef UART_TX_BREAK_EN
      , ST_BREAK
`endif
   } tx_state_t;

   // Clocks per bit, rounded to nearest.
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

   // Bit times in one frame: start + data + optional parity + stop.
   function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// rtl/uart_frame_tx_if.sv - write-side bundle between the character producer and uart_frame_tx
interface uart_frame_tx_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   logic                          wr_en;
   logic [DATA_BITS-1:0]          wr_data;
   logic                          wr_ready;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;

   modport master (
      output wr_en,
      output wr_data,
      input  wr_ready,
      input  fifo_level
   );

   modport slave (
      input  wr_en,
      input  wr_data,
      output wr_ready,
      output fifo_level
   );
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock show-ahead FIFO with level and registered full/empty flags
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic [LW-1:0]    level_d;

   // full/empty come from flops, so a same-edge pop never lets a full FIFO accept
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // next occupancy
   always_comb begin
      level_d = level + LW'(push_ok) - LW'(pop_ok);
   end

   // pointers, occupancy and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         level <= level_d;
         full  <= (level_d == FULL_LVL);
         empty <= (level_d == '0);
      end
   end

   // storage array, contents need no reset
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - framed UART transmitter with write FIFO and baud generator; UART_TX_BREAK_EN adds break_req/BREAK
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int BREAK_BITS = 12
) (
   input  logic            clk,
   input  logic            rst_n,
`ifdef UART_TX_BREAK_EN
   input  logic            break_req,
`endif
   uart_frame_tx_if.slave  wr,
   output logic            busy,
   output logic            frame_done,
   output logic            uart_tx
);
   localparam int DIV  = calc_div(CLK_HZ, BAUD);
   localparam int CW   = $clog2(DIV);
   localparam int BMAX = (BREAK_BITS > DATA_BITS) ? BREAK_BITS : DATA_BITS;
   localparam int BW   = $clog2(BMAX + 1);

   tx_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 tick;
   logic                 load;
   logic                 pop;
   logic [DATA_BITS-1:0] head;
   logic                 fifo_full;
   logic                 fifo_empty;

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wr.wr_en),
      .push_data (wr.wr_data),
      .pop       (pop),
      .pop_data  (head),
      .level     (wr.fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign wr.wr_ready = ~fifo_full;
   assign tick        = (cnt_q == CW'(DIV - 1));
   assign uart_tx     = tx_q;
   assign busy        = (state_q != ST_IDLE);

   // state, baud counter, shifter and the registered line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   // bit sequencing; load pops the FIFO head and starts a frame, also straight out of STOP
   always_comb begin
      state_d    = state_q;
      cnt_d      = tick ? '0 : cnt_q + CW'(1);
      bit_d      = bit_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tx_d       = tx_q;
      pop        = 1'b0;
      frame_done = 1'b0;
      load       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
`ifdef UART_TX_BREAK_EN
            if (break_req) begin
               state_d = ST_BREAK;
               tx_d    = 1'b0;
               bit_d   = '0;
            end else if (!fifo_empty) begin
               load = 1'b1;
            end
`else
            if (!fifo_empty) load = 1'b1;
`endif
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  bit_d = '0;
                  if (PARITY != PAR_NONE) begin
                     state_d = ST_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + BW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_q == BW'(STOP_BITS - 1)) begin
                  frame_done = 1'b1;
                  if (!fifo_empty) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         ST_BREAK: begin
            // BREAK_BITS low bit times, then one mark bit time before IDLE
            if (tick) begin
               if (bit_q == BW'(BREAK_BITS)) begin
                  state_d = ST_IDLE;
               end else begin
                  bit_d = bit_q + BW'(1);
                  if (bit_q == BW'(BREAK_BITS - 1)) tx_d = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
      if (load) begin
         pop     = 1'b1;
         state_d = ST_START;
         shift_d = head;
         par_d   = (PARITY == PAR_ODD) ? ~^head : ^head;
         tx_d    = 1'b0;
         cnt_d   = '0;
         bit_d   = '0;
      end
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - self-checking bench for uart_frame_tx; define UART_TX_BREAK_EN to cover break
module tb_uart_frame_tx;
   logic clk = 1'b0;
   logic rst_n;
   logic rst0_n;
   int   total = 0;
   int   bad   = 0;

   logic       tx     [6];
   logic       busy_s [6];
   logic       done_s [6];
   logic       rdy    [6];
   logic [4:0] lvl    [6];
   logic       wen    [6];
   logic [8:0] wdat   [6];
`ifdef UART_TX_BREAK_EN
   logic       brk    [6];
`endif

   // per-instance configuration: clocks per bit, data bits, parity mode, stop bits
   int divs [6] = '{434, 4, 5, 4, 4, 3};
   int nds  [6] = '{8, 8, 8, 5, 8, 8};
   int pars [6] = '{0, 2, 1, 0, 0, 0};
   int nss  [6] = '{1, 1, 1, 1, 1, 2};
   int ks   [5] = '{1, 2, 3, 4, 5};

   always #5 clk = ~clk;

   uart_frame_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if0 ();
   uart_frame_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if1 ();
   uart_frame_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if2 ();
   uart_frame_tx_if #(.DATA_BITS(5), .FIFO_DEPTH(16)) if3 ();
   uart_frame_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if4 ();
   uart_frame_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if5 ();

   assign if0.wr_en = wen[0]; assign if0.wr_data = wdat[0][7:0];
   assign if1.wr_en = wen[1]; assign if1.wr_data = wdat[1][7:0];
   assign if2.wr_en = wen[2]; assign if2.wr_data = wdat[2][7:0];
   assign if3.wr_en = wen[3]; assign if3.wr_data = wdat[3][4:0];
   assign if4.wr_en = wen[4]; assign if4.wr_data = wdat[4][7:0];
   assign if5.wr_en = wen[5]; assign if5.wr_data = wdat[5][7:0];
   assign rdy[0] = if0.wr_ready; assign lvl[0] = if0.fifo_level;
   assign rdy[1] = if1.wr_ready; assign lvl[1] = if1.fifo_level;
   assign rdy[2] = if2.wr_ready; assign lvl[2] = if2.fifo_level;
   assign rdy[3] = if3.wr_ready; assign lvl[3] = if3.fifo_level;
   assign rdy[4] = if4.wr_ready; assign lvl[4] = if4.fifo_level;
   assign rdy[5] = if5.wr_ready; assign lvl[5] = if5.fifo_level;

   uart_frame_tx u0 (
      .clk(clk), .rst_n(rst0_n),
`ifdef UART_TX_BREAK_EN
      .break_req(brk[0]),
`endif
      .wr(if0), .busy(busy_s[0]), .frame_done(done_s[0]), .uart_tx(tx[0]));

   uart_frame_tx #(.CLK_HZ(1000), .BAUD(250), .PARITY(2)) u1 (
      .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
      .break_req(brk[1]),
`endif
      .wr(if1), .busy(busy_s[1]), .frame_done(done_s[1]), .uart_tx(tx[1]));

   uart_frame_tx #(.CLK_HZ(1000), .BAUD(200), .PARITY(1)) u2 (
      .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
      .break_req(brk[2]),
`endif
      .wr(if2), .busy(busy_s[2]), .frame_done(done_s[2]), .uart_tx(tx[2]));

   uart_frame_tx #(.CLK_HZ(1000), .BAUD(250), .DATA_BITS(5)) u3 (
      .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
      .break_req(brk[3]),
`endif
      .wr(if3), .busy(busy_s[3]), .frame_done(done_s[3]), .uart_tx(tx[3]));

   uart_frame_tx #(.CLK_HZ(1000), .BAUD(250)) u4 (
      .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
      .break_req(brk[4]),
`endif
      .wr(if4), .busy(busy_s[4]), .frame_done(done_s[4]), .uart_tx(tx[4]));

   uart_frame_tx #(.CLK_HZ(1000), .BAUD(333), .STOP_BITS(2)) u5 (
      .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
      .break_req(brk[5]),
`endif
      .wr(if5), .busy(busy_s[5]), .frame_done(done_s[5]), .uart_tx(tx[5]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // expected line sequence, LSB-first, built from the framing rules
   function automatic int make_frame(input int k, input logic [8:0] d, output logic [15:0] bits);
      int n;
      int ones;
      bits = '0;
      ones = 0;
      for (int i = 0; i < nds[k]; i++) begin
         bits[1 + i] = d[i];
         if (d[i]) ones++;
      end
      n = 1 + nds[k];
      if (pars[k] != 0) begin
         bits[n] = (pars[k] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
         n++;
      end
      for (int s = 0; s < nss[k]; s++) bits[n + s] = 1'b1;
      return n + nss[k];
   endfunction

   task automatic write_char(input int k, input logic [8:0] d);
      wen[k]  = 1'b1;
      wdat[k] = d;
      @(negedge clk);
      wen[k]  = 1'b0;
   endtask

   // expects the next rising edge to be the one that starts the frame
   task automatic check_frame(input int k, input logic [8:0] d, input string tag);
      logic [15:0] bits;
      logic        obs;
      int          nb;
      int          dcnt;
      int          dpos;
      int          nbusy;
      nb    = make_frame(k, d, bits);
      dcnt  = 0;
      dpos  = -1;
      nbusy = 0;
      for (int b = 0; b < nb; b++) begin
         obs = bits[b];
         for (int c = 0; c < divs[k]; c++) begin
            @(negedge clk);
            if (tx[k] !== bits[b] && obs === bits[b]) obs = tx[k];
            if (done_s[k] !== 1'b0) begin
               dcnt++;
               if (dpos < 0) dpos = b * divs[k] + c;
            end
            if (busy_s[k] !== 1'b1) nbusy++;
         end
         chk($sformatf("%s bit%0d", tag, b), obs, bits[b]);
      end
      chk($sformatf("%s done_count", tag), dcnt, 1);
      chk($sformatf("%s done_clock", tag), dpos, nb * divs[k] - 1);
      chk($sformatf("%s busy_drop", tag), nbusy, 0);
   endtask

   task automatic expect_idle(input int k, input string tag);
      @(negedge clk);
      chk($sformatf("%s busy", tag), busy_s[k], 1'b0);
      chk($sformatf("%s line", tag), tx[k], 1'b1);
      chk($sformatf("%s done", tag), done_s[k], 1'b0);
   endtask

   task automatic send_one(input int k, input logic [8:0] d, input string tag);
      write_char(k, d);
      chk($sformatf("%s latency", tag), tx[k], 1'b1);
      check_frame(k, d, tag);
      expect_idle(k, {tag, " end"});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int nt;
      int nd;
      int nb;
      rst_n  = 1'b0;
      rst0_n = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wen[k]  = 1'b0;
         wdat[k] = '0;
`ifdef UART_TX_BREAK_EN
         brk[k]  = 1'b0;
`endif
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rst%0d tx", k), tx[k], 1'b1);
         chk($sformatf("rst%0d ready", k), rdy[k], 1'b1);
         chk($sformatf("rst%0d level", k), lvl[k], 0);
         chk($sformatf("rst%0d busy", k), busy_s[k], 1'b0);
         chk($sformatf("rst%0d done", k), done_s[k], 1'b0);
      end
      rst_n  = 1'b1;
      rst0_n = 1'b1;
      repeat (2) @(negedge clk);

      send_one(0, 9'h41, "def_41");
      send_one(1, 9'h41, "even_41");
      send_one(2, 9'h41, "odd_41");
      send_one(3, 9'h1F, "d5_1f");
      send_one(5, 9'h41, "stop2_41");

      // 18 writes on consecutive cycles into an idle transmitter
      fork
         begin
            for (int i = 0; i < 18; i++) begin
               write_char(4, 9'(i));
               if (i == 1) chk("push_pop level", lvl[4], 1);
            end
            chk("burst level", lvl[4], 16);
            chk("burst ready", rdy[4], 1'b0);
         end
         begin
            @(negedge clk);
            for (int i = 0; i < 17; i++) check_frame(4, 9'(i), $sformatf("burst%0d", i));
         end
      join
      expect_idle(4, "burst end");
      chk("burst drained", lvl[4], 0);
      chk("burst ready back", rdy[4], 1'b1);

      // random bursts across the configurations
      for (int r = 0; r < 10; r++) begin : rnd
         int k;
         int n;
         logic [8:0] q [$];
         k = ks[r % 5];
         n = $urandom_range(1, 6);
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(9'($urandom) & 9'((1 << nds[k]) - 1));
         fork
            begin
               for (int i = 0; i < n; i++) write_char(k, q[i]);
            end
            begin
               @(negedge clk);
               for (int i = 0; i < n; i++) check_frame(k, q[i], $sformatf("rnd%0d_%0d", r, i));
            end
         join
         expect_idle(k, $sformatf("rnd%0d end", r));
      end

      // reset in the middle of a frame with more entries queued
      write_char(0, 9'h55);
      write_char(0, 9'hAA);
      write_char(0, 9'h0F);
      repeat (998) @(negedge clk);
      chk("mid busy", busy_s[0], 1'b1);
      chk("mid level", lvl[0], 2);
      chk("mid line", tx[0], 1'b0);
      #2 rst0_n = 1'b0;
      #1;
      chk("async tx", tx[0], 1'b1);
      chk("async level", lvl[0], 0);
      chk("async busy", busy_s[0], 1'b0);
      chk("async ready", rdy[0], 1'b1);
      chk("async done", done_s[0], 1'b0);
      repeat (3) @(negedge clk);
      rst0_n = 1'b1;
      nt = 0;
      nd = 0;
      nb = 0;
      for (int j = 0; j < 1000; j++) begin
         @(negedge clk);
         if (tx[0] !== 1'b1) nt++;
         if (done_s[0] !== 1'b0) nd++;
         if (busy_s[0] !== 1'b0) nb++;
      end
      chk("post rst line", nt, 0);
      chk("post rst done", nd, 0);
      chk("post rst busy", nb, 0);

`ifdef UART_TX_BREAK_EN
      begin : brk_test
         int bt;
         int bb;
         int bd;
         bt = 0;
         bb = 0;
         bd = 0;
         write_char(4, 9'h5A);
         brk[4] = 1'b1;
         for (int j = 0; j < 52; j++) begin
            @(negedge clk);
            brk[4] = 1'b0;
            if (tx[4] !== ((j < 48) ? 1'b0 : 1'b1)) bt++;
            if (busy_s[4] !== 1'b1) bb++;
            if (done_s[4] !== 1'b0) bd++;
         end
         chk("break line", bt, 0);
         chk("break busy", bb, 0);
         chk("break done", bd, 0);
         @(negedge clk);
         chk("break idle busy", busy_s[4], 1'b0);
         chk("break idle line", tx[4], 1'b1);
         chk("break queued", lvl[4], 1);
         check_frame(4, 9'h5A, "after_break");
         expect_idle(4, "after_break end");
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
